pellet_countdown: RTL
=====================

# pellet_countdown

BCD down-counter for timed game phases (power-pellet frightened window, round timers). It is the counting inverse of the up-counting stopwatch: it loads an mm:ss.t value, decrements once per 0.1 s tick, flags the final seconds and pulses on expiry. It sits beside the stopwatch in the game-control logic, and its digits feed the same hex display path.

## Interface
- TICK_DIV, 5000000, Clk cycles per 0.1 s tick (50 MHz).
- WARN_TENTHS, 20, warn threshold in tenths of a second (2.0 s).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Load  in  1  copy load_hex0..3 into the digits
- load_hex0 / load_hex1 / load_hex2 / load_hex3  in  4 each  load value: tenths, seconds, tens of seconds, minutes
- Start  in  1  start or resume counting
- Pause  in  1  suspend counting
- Kill  in  1  freeze the prescaler while high
- hex0 / hex1 / hex2 / hex3  out  4 each  current BCD digits
- running  out  1  high in RUN
- expired  out  1  one-cycle pulse when the count reaches 0000
- warn  out  1  remaining time is low (see Configuration)

## Operation
- Digit ranges: hex0, hex1, hex3 are 0–9; hex2 is 0–5.
- States: IDLE, RUN, PAUSED, DONE.
- Reset: IDLE, all digits 0, prescaler 0, running/expired/warn 0.
- Load (any state, highest priority):
  - Each digit is clamped to its maximum (for example, load_hex2=7 gives 5).
  - Prescaler is cleared and the state goes to IDLE.
- IDLE + Start with a nonzero value: go to RUN. Start with value 0000 is ignored.
- RUN:
  - Pause: go to PAUSED. Pause wins over Start in the same cycle.
  - Pause is ignored in all other states.
- PAUSED:
  - Start: go to RUN.
  - Prescaler value is retained.
- DONE: digits 0000. Only Load leaves DONE.
- Decrement with borrow:
  - hex0 counts down; at 0 it wraps to 9 and borrows from hex1.
  - hex1 wraps 0→9 and borrows from hex2.
  - hex2 wraps 0→5 and borrows from hex3.
  - Value 0000 is never decremented.
- When a tick leaves 0000: state goes to DONE and expired is high for that one cycle.
- Reset mid-operation returns everything to reset values immediately.

## Timing
- Prescaler increments on every RUN cycle where Kill is low; it holds when Kill is high.
- At count TICK_DIV-1 on an edge: the digits decrement and the prescaler returns to 0 on that same edge.
- Start sampled at edge E0: the first decrement occurs at edge E0+TICK_DIV, then every TICK_DIV cycles.
- Kill high for N cycles delays every following tick by N cycles.
- Digits, state, running and expired are registered and update together on the tick edge.
- warn is combinational from the registered digits and state: zero extra latency.
- Load and a tick on the same edge: Load wins and no decrement happens.

## Configuration
- COUNTDOWN_WARN_EN defined:
  - warn = running AND remaining tenths ≤ WARN_TENTHS AND remaining tenths ≠ 0.
  - Remaining tenths = hex3·600 + hex2·100 + hex1·10 + hex0, computed as a 13-bit unsigned value (max 5999).
- COUNTDOWN_WARN_EN undefined: warn is tied to 0, no comparison logic is built, and the port remains.

## Structure
- Package pacman_timer_pkg: countdown state enum, bcd_t (4-bit) typedef, digit maximum constants (9 and 5).
- Sub-module tick_prescaler:
  - Inputs: enable, clear.
  - Holds the counter up to TICK_DIV-1.
  - Outputs a one-cycle tick.
  - Shared with future timers.

## Test plan
All scenarios run with TICK_DIV=4.
- Load 0:01.0, Start → digits reach 0000 at edge E0+40 (10 ticks); expired high for exactly that cycle; state DONE; running 0.
- Load 1:00.0, Start → after one tick (4 cycles) digits read 0:59.9.
- Start, Pause after 2 ticks, hold 20 cycles, Start → digits frozen during the pause; next tick exactly 4 cycles after resume minus prescaler cycles already counted.
- Kill high for 8 cycles during RUN → next decrement delayed by 8 cycles; the value is unaffected otherwise.
- COUNTDOWN_WARN_EN, WARN_TENTHS=20, load 0:03.0, Start → warn rises the cycle digits become 0:02.0 (tick 10) and falls at 0000.
- Load with hex2=7, then assert Reset during RUN → digits load as x5xx; Reset returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/pacman_timer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// pacman_timer_pkg : shared types and BCD helpers for the game-phase timers
// Rev 1.0
// ---------------------------------------------------------------------------
package pacman_timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } cd_state_t;

    localparam bcd_t C_MAX_DEC = 4'd9;
    localparam bcd_t C_MAX_SEX = 4'd5;

    function automatic bcd_t bcd_clamp(input bcd_t d, input bcd_t max);
        return (d > max) ? max : d;
    endfunction

    // One digit step down; a zero digit wraps to its maximum.
    function automatic bcd_t bcd_dec(input bcd_t d, input bcd_t max);
        return (d == 4'd0) ? max : d - 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tick_prescaler : counts enabled cycles 0..TICK_DIV-1, one-cycle tick at wrap
// Rev 1.0
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 5000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_TERMINAL = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_end;

    assign w_at_end = (r_count == C_TERMINAL);
    assign tick     = enable && w_at_end && !clear;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_at_end ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pellet_countdown.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// pellet_countdown : mm:ss.t BCD down-counter with expiry pulse and low-time
// warning. Define COUNTDOWN_WARN_EN to build the warn comparator. Rev 1.0
// ---------------------------------------------------------------------------
module pellet_countdown
    import pacman_timer_pkg::*;
#(
    parameter int TICK_DIV    = 5000000,
    parameter int WARN_TENTHS = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic [3:0] load_hex0,
    input  logic [3:0] load_hex1,
    input  logic [3:0] load_hex2,
    input  logic [3:0] load_hex3,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Kill,
    output logic [3:0] hex0,
    output logic [3:0] hex1,
    output logic [3:0] hex2,
    output logic [3:0] hex3,
    output logic       running,
    output logic       expired,
    output logic       warn
);

    cd_state_t r_state, w_next_state;
    bcd_t      r_hex0, r_hex1, r_hex2, r_hex3;
    bcd_t      w_dec0, w_dec1, w_dec2, w_dec3;
    logic      w_b0, w_b1, w_b2;
    logic      w_is_zero, w_dec_zero;
    logic      w_tick, w_presc_en;
    logic      r_expired;

    assign w_presc_en = (r_state == ST_RUN) && !Kill;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .Clk    (Clk),
        .Reset  (Reset),
        .enable (w_presc_en),
        .clear  (Load),
        .tick   (w_tick)
    );

    // Borrow ripples upward only while every lower digit is zero.
    assign w_b0   = (r_hex0 == 4'd0);
    assign w_b1   = w_b0 && (r_hex1 == 4'd0);
    assign w_b2   = w_b1 && (r_hex2 == 4'd0);
    assign w_dec0 = bcd_dec(r_hex0, C_MAX_DEC);
    assign w_dec1 = w_b0 ? bcd_dec(r_hex1, C_MAX_DEC) : r_hex1;
    assign w_dec2 = w_b1 ? bcd_dec(r_hex2, C_MAX_SEX) : r_hex2;
    assign w_dec3 = w_b2 ? bcd_dec(r_hex3, C_MAX_DEC) : r_hex3;

    assign w_is_zero  = ({r_hex3, r_hex2, r_hex1, r_hex0} == 16'h0000);
    assign w_dec_zero = ({w_dec3, w_dec2, w_dec1, w_dec0} == 16'h0000);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (Start && !w_is_zero) w_next_state = ST_RUN;
            ST_RUN: begin
                if (w_tick && w_dec_zero) w_next_state = ST_DONE;
                else if (Pause)           w_next_state = ST_PAUSED;
            end
            ST_PAUSED: if (Start) w_next_state = ST_RUN;
            ST_DONE:   w_next_state = ST_DONE;
            default:   w_next_state = ST_IDLE;
        endcase
        if (Load) w_next_state = ST_IDLE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hex0    <= 4'd0;
            r_hex1    <= 4'd0;
            r_hex2    <= 4'd0;
            r_hex3    <= 4'd0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (Load) begin
                r_hex0 <= bcd_clamp(load_hex0, C_MAX_DEC);
                r_hex1 <= bcd_clamp(load_hex1, C_MAX_DEC);
                r_hex2 <= bcd_clamp(load_hex2, C_MAX_SEX);
                r_hex3 <= bcd_clamp(load_hex3, C_MAX_DEC);
            end else if (w_tick) begin
                r_hex0    <= w_dec0;
                r_hex1    <= w_dec1;
                r_hex2    <= w_dec2;
                r_hex3    <= w_dec3;
                r_expired <= w_dec_zero;
            end
        end
    end

    assign hex0    = r_hex0;
    assign hex1    = r_hex1;
    assign hex2    = r_hex2;
    assign hex3    = r_hex3;
    assign running = (r_state == ST_RUN);
    assign expired = r_expired;

`ifdef COUNTDOWN_WARN_EN
    localparam logic [12:0] C_WARN_LIMIT = 13'(WARN_TENTHS);
    logic [12:0] w_remaining;

    assign w_remaining = 13'(r_hex3) * 13'd600 + 13'(r_hex2) * 13'd100
                       + 13'(r_hex1) * 13'd10  + 13'(r_hex0);
    assign warn = running && (w_remaining <= C_WARN_LIMIT) && (w_remaining != 13'd0);
`else
    localparam logic [12:0] C_WARN_LIMIT = 13'(WARN_TENTHS);
    logic w_unused_warn_cfg;

    assign w_unused_warn_cfg = ^C_WARN_LIMIT;
    assign warn = 1'b0;
`endif

endmodule
`default_nettype wire
